coinc_readout_tx: RTL and testbench

- Readout transmitter that drives the `dt` advance input of the channel-shuffle block and consumes its 4-bit `selection` index.
- At the end of each coincidence integration window it snapshots all channel counters.
- For each shuffled selection it serialises one framed record over a UART 8N1 line, then toggles `dt` to request the next selection.
- Sits between the counter bank and the host UART pin.

---
 rtl/coinc_readout_tx.sv | 210 +++++++++++++++++++++
 tb/tb_coinc_readout_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coinc_readout_tx.sv
// Coincidence readout transmitter: snapshots the counter bank once per window and
// sends one UART 8N1 frame per shuffled selection. Optional macro: READOUT_CHECKSUM_EN.
module coinc_readout_tx #(
    parameter int NUM_CH       = 8,
    parameter int COUNT_W      = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int SETTLE       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      window_done,
    input  logic [NUM_CH*COUNT_W-1:0] counts,
    input  logic [3:0]                selection,
    output logic                      dt,
    output logic                      tx,
    output logic                      busy,
    output logic                      overrun
);

    localparam int NBYTES  = COUNT_W / 8;
    localparam int DIV_MAX = (CLKS_PER_BIT > SETTLE) ? CLKS_PER_BIT : SETTLE;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);
    localparam int BYTE_W  = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SNAP, S_SAMPLE, S_HDR, S_DATA,
`ifdef READOUT_CHECKSUM_EN
        S_CSUM,
`endif
        S_ADV, S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [COUNT_W-1:0]  snap_q [NUM_CH];
    logic [COUNT_W-1:0]  snap_d [NUM_CH];
    logic [COUNT_W-1:0]  pay_q, pay_d;
    logic [8:0]          sh_q, sh_d;
    logic [3:0]          bit_q, bit_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [4:0]          fcnt_q, fcnt_d;
    logic                tx_q, tx_d;
    logic                dt_q, dt_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic       bit_done;
    logic       oor;
    logic [7:0] hdr;
    logic [7:0] next_byte;

    assign bit_done  = (div_q == DIV_W'(CLKS_PER_BIT - 1));
    assign next_byte = pay_q[COUNT_W-1 -: 8];

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        pay_d     = pay_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        div_d     = div_q;
        byte_d    = byte_q;
        fcnt_d    = fcnt_q;
        tx_d      = tx_q;
        dt_d      = dt_q;
        busy_d    = busy_q;
        overrun_d = overrun_q | (window_done & busy_q);
        oor       = 1'b1;
        hdr       = 8'h00;
`ifdef READOUT_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (window_done) begin
                    for (int k = 0; k < NUM_CH; k++) snap_d[k] = counts[k*COUNT_W +: COUNT_W];
                    busy_d  = 1'b1;
                    state_d = S_SNAP;
                end
            end
            S_SNAP: begin
                fcnt_d  = 5'd0;
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                pay_d = '0;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (int'(selection) == k) begin
                        oor   = 1'b0;
                        pay_d = snap_q[k];
                    end
                end
                hdr     = {3'b101, oor, selection};
                sh_d    = {1'b1, hdr};
                tx_d    = 1'b0;
                bit_d   = 4'd0;
                div_d   = '0;
                byte_d  = BYTE_W'(NBYTES);
`ifdef READOUT_CHECKSUM_EN
                csum_d  = hdr;
`endif
                state_d = S_HDR;
            end
            S_ADV: begin
                dt_d    = ~dt_q;
                fcnt_d  = fcnt_q + 5'd1;
                div_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_q == DIV_W'(SETTLE - 1)) begin
                    div_d = '0;
                    if (fcnt_q == 5'(NUM_CH)) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                // Byte sender shared by header, payload and checksum bytes; the next
                // start bit follows the stop bit with no gap.
                if (!bit_done) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (bit_q != 4'd9) begin
                        tx_d  = sh_q[0];
                        sh_d  = {1'b1, sh_q[8:1]};
                        bit_d = bit_q + 4'd1;
                    end else if (byte_q != '0) begin
                        tx_d    = 1'b0;
                        sh_d    = {1'b1, next_byte};
                        pay_d   = pay_q << 8;
                        byte_d  = byte_q - BYTE_W'(1);
                        bit_d   = 4'd0;
`ifdef READOUT_CHECKSUM_EN
                        csum_d  = csum_q ^ next_byte;
`endif
                        state_d = S_DATA;
`ifdef READOUT_CHECKSUM_EN
                    end else if (state_q == S_DATA) begin
                        tx_d    = 1'b0;
                        sh_d    = {1'b1, csum_q};
                        bit_d   = 4'd0;
                        state_d = S_CSUM;
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_ADV;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pay_q     <= '0;
            sh_q      <= '1;
            bit_q     <= 4'd0;
            div_q     <= '0;
            byte_q    <= '0;
            fcnt_q    <= 5'd0;
            tx_q      <= 1'b1;
            dt_q      <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            pay_q     <= pay_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            byte_q    <= byte_d;
            fcnt_q    <= fcnt_d;
            tx_q      <= tx_d;
            dt_q      <= dt_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef READOUT_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // NOTE: the snapshot is a plain data store written only on an accepted window, so it has no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign dt      = dt_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_coinc_readout_tx.sv
// Directed bench for coinc_readout_tx: small configuration, UART frames decoded
// cycle by cycle and compared with hand-computed bytes.
module tb_coinc_readout_tx;

    localparam int NUM_CH   = 2;
    localparam int COUNT_W  = 16;
    localparam int CPB      = 4;
    localparam int SETTLE   = 4;
    localparam int TO       = 1000;
`ifdef READOUT_CHECKSUM_EN
    localparam int FB       = 4;
`else
    localparam int FB       = 3;
`endif
    // SNAP, then per frame: SAMPLE + FB bytes + ADV + SETTLE wait cycles.
    localparam int BUSY_EXP = 1 + NUM_CH * (2 + 10 * FB * CPB + SETTLE);

    logic                      clk;
    logic                      rst;
    logic                      window_done;
    logic [NUM_CH*COUNT_W-1:0] counts;
    logic [3:0]                selection;
    logic                      dt;
    logic                      tx;
    logic                      busy;
    logic                      overrun;

    int checks;
    int errors;
    int busy_cycles;
    int dt_toggles;
    logic [3:0] sel_next;

    coinc_readout_tx #(
        .NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .CLKS_PER_BIT(CPB), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .window_done(window_done), .counts(counts),
        .selection(selection), .dt(dt), .tx(tx), .busy(busy), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(negedge clk);
        if (busy === 1'b1) busy_cycles++;
    end

    // The shuffle block answers each dt toggle with a new selection.
    initial forever begin
        @(dt);
        dt_toggles++;
        selection = sel_next;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_window();
        @(posedge clk);
        #1 window_done = 1'b1;
        @(posedge clk);
        #1 window_done = 1'b0;
    endtask

    task automatic rx_byte(input bit first, output logic [7:0] b, output int waited);
        logic [9:0] bits;
        bit bad;
        waited = 0;
        bad    = 1'b0;
        @(negedge clk);
        if (first) begin
            while (tx !== 1'b0 && waited < TO) begin
                waited++;
                @(negedge clk);
            end
        end
        for (int i = 0; i < 10; i++) begin
            bits[i] = tx;
            for (int j = 1; j < CPB; j++) begin
                @(negedge clk);
                if (tx !== bits[i]) bad = 1'b1;
            end
            if (i < 9) @(negedge clk);
        end
        check("rx_start_bit", {31'd0, bits[0]}, 32'd0);
        check("rx_stop_bit", {31'd0, bits[9]}, 32'd1);
        check("rx_bit_width", {31'd0, bad}, 32'd0);
        b = bits[8:1];
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] hdr, input logic [15:0] pay,
                            output int waited);
        logic [7:0] b;
        int w;
        rx_byte(1'b1, b, waited);
        check({tag, "_hdr"}, {24'd0, b}, {24'd0, hdr});
        rx_byte(1'b0, b, w);
        check({tag, "_msb"}, {24'd0, b}, {24'd0, pay[15:8]});
        rx_byte(1'b0, b, w);
        check({tag, "_lsb"}, {24'd0, b}, {24'd0, pay[7:0]});
`ifdef READOUT_CHECKSUM_EN
        rx_byte(1'b0, b, w);
        check({tag, "_csum"}, {24'd0, b}, {24'd0, hdr ^ pay[15:8] ^ pay[7:0]});
`endif
    endtask

    task automatic wait_busy_low();
        int n = 0;
        while (busy !== 1'b0 && n < TO) begin
            n++;
            @(negedge clk);
        end
        check("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    task automatic count_tx_falls(input int n, output int falls);
        logic prev;
        falls = 0;
        prev  = tx;
        repeat (n) begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) falls++;
            prev = tx;
        end
    endtask

    initial begin
        int w;
        int falls;
        checks      = 0;
        errors      = 0;
        busy_cycles = 0;
        dt_toggles  = 0;
        rst         = 1'b1;
        window_done = 1'b0;
        counts      = '0;
        selection   = 4'd0;
        sel_next    = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_dt", {31'd0, dt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Main window: selection 1 then 0.
        counts      = {16'hABCD, 16'h1234};
        selection   = 4'd1;
        sel_next    = 4'd0;
        busy_cycles = 0;
        dt_toggles  = 0;
        pulse_window();
        rx_frame("a_f1", 8'hA1, 16'hABCD, w);
        check("a_first_latency", w + 1, 3);
        rx_frame("a_f2", 8'hA0, 16'h1234, w);
        check("a_frame_gap", w, SETTLE + 2);
        wait_busy_low();
        check("a_dt_final", {31'd0, dt}, 32'd0);
        check("a_dt_toggles", dt_toggles, 2);
        check("a_busy_cycles", busy_cycles, BUSY_EXP);
        check("a_overrun", {31'd0, overrun}, 32'd0);

        // Out-of-range selection.
        selection = 4'd9;
        sel_next  = 4'd9;
        pulse_window();
        rx_frame("b_f1", 8'hB9, 16'h0000, w);
        rx_frame("b_f2", 8'hB9, 16'h0000, w);
        wait_busy_low();
        check("b_overrun", {31'd0, overrun}, 32'd0);

        // window_done in the very cycle busy falls is still an overrun.
        selection = 4'd0;
        sel_next  = 4'd0;
        pulse_window();
        rx_frame("d_f1", 8'hA0, 16'h1234, w);
        rx_frame("d_f2", 8'hA0, 16'h1234, w);
        repeat (SETTLE + 1) @(negedge clk);
        check("d_busy_last_wait", {31'd0, busy}, 32'd1);
        window_done = 1'b1;
        @(negedge clk);
        window_done = 1'b0;
        check("d_busy_fell", {31'd0, busy}, 32'd0);
        check("d_overrun", {31'd0, overrun}, 32'd1);
        count_tx_falls(200, falls);
        check("d_no_restart", falls, 0);

        // Asynchronous reset in the middle of the second frame.
        selection = 4'd1;
        sel_next  = 4'd1;
        pulse_window();
        w = 0;
        while (dt !== 1'b1 && w < TO) begin
            w++;
            @(negedge clk);
        end
        check("e_dt_toggled", {31'd0, dt}, 32'd1);
        w = 0;
        while (tx !== 1'b0 && w < TO) begin
            w++;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("e_rst_tx", {31'd0, tx}, 32'd1);
        check("e_rst_dt", {31'd0, dt}, 32'd0);
        check("e_rst_busy", {31'd0, busy}, 32'd0);
        check("e_rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        count_tx_falls(200, falls);
        check("e_tx_quiet", falls, 0);

        // Overrun mid-frame: new counts must not reach the wire.
        counts      = {16'h2468, 16'h1357};
        selection   = 4'd0;
        sel_next    = 4'd1;
        busy_cycles = 0;
        dt_toggles  = 0;
        pulse_window();
        fork
            begin
                rx_frame("c_f1", 8'hA0, 16'h1357, w);
                rx_frame("c_f2", 8'hA1, 16'h2468, w);
            end
            begin
                repeat (20) @(negedge clk);
                counts      = 32'hFFFF_FFFF;
                window_done = 1'b1;
                @(negedge clk);
                window_done = 1'b0;
                @(negedge clk);
                check("c_overrun_set", {31'd0, overrun}, 32'd1);
            end
        join
        wait_busy_low();
        check("c_busy_cycles", busy_cycles, BUSY_EXP);
        check("c_dt_toggles", dt_toggles, 2);
        check("c_overrun_sticky", {31'd0, overrun}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
